// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
// Single-cycle ops (add, sub, xor, and, or) load the output registers on the
// accept edge. Unsigned multiply runs as WIDTH shift-add iterations before the
// result is presented. Results are held until the consumer takes them.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       mode,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             zero,
   output logic             err
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [2:0] MODE_ADD = 3'd0;
   localparam logic [2:0] MODE_SUB = 3'd1;
   localparam logic [2:0] MODE_XOR = 3'd2;
   localparam logic [2:0] MODE_AND = 3'd3;
   localparam logic [2:0] MODE_OR  = 3'd4;
   localparam logic [2:0] MODE_MUL = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 c_out_q, c_out_d;
   logic                 zero_q, zero_d;
   logic                 err_q, err_d;

   logic [WIDTH+1:0]     single;
   logic [2*WIDTH-1:0]   partial;
   logic [2*WIDTH-1:0]   acc_sum;

   // Single-cycle operations; returns {err, carry, result}. Illegal modes give
   // an all-zero result with err set.
   function automatic logic [WIDTH+1:0] alu_single(
      input logic [WIDTH-1:0] op_a,
      input logic [WIDTH-1:0] op_b,
      input logic [2:0]       op_mode,
      input logic             op_cin
   );
      logic [WIDTH:0] sum;
      logic           bad;
      sum = '0;
      bad = 1'b0;
      case (op_mode)
         MODE_ADD: sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
         // Carry out of a + ~b + 1 is the "no borrow" flag (a >= b).
         MODE_SUB: sum = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
         MODE_XOR: sum = {1'b0, op_a ^ op_b};
         MODE_AND: sum = {1'b0, op_a & op_b};
         MODE_OR:  sum = {1'b0, op_a | op_b};
         MODE_MUL: sum = '0;
         default:  bad = 1'b1;
      endcase
      return {bad, sum};
   endfunction

   assign single  = alu_single(a, b, mode, c_in);
   // Partial product: A shifted by the iteration index when the current B bit is set.
   assign partial = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
   assign acc_sum = acc_q + partial;

   // Next-state and datapath decode for the handshake FSM and multiplier.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      zero_d   = zero_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (mode == MODE_MUL) begin
                  state_d  = S_MUL;
                  mcand_d  = a;
                  mplier_d = b;
                  acc_d    = '0;
                  cnt_d    = '0;
               end else begin
                  state_d  = S_DONE;
                  result_d = single[WIDTH-1:0];
                  c_out_d  = single[WIDTH];
                  err_d    = single[WIDTH+1];
                  zero_d   = (single[WIDTH-1:0] == '0);
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_sum;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               state_d  = S_DONE;
               result_d = acc_sum[WIDTH-1:0];
               c_out_d  = |acc_sum[2*WIDTH-1:WIDTH];
               zero_d   = (acc_sum[WIDTH-1:0] == '0);
               err_d    = 1'b0;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, multiplier and output registers; reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign c_out     = c_out_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH = 8): directed cases, randomized
// operations against an arithmetic reference model, backpressure, abort.
module tb_seq_alu;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   mode;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         c_out;
   logic         zero;
   logic         err;

   int n_cmp = 0;
   int n_bad = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode), .c_in(c_in), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .c_out(c_out), .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the operation rules.
   function automatic void ref_op(input int ra, input int rb, input int rm, input int rc,
                                  output int res, output bit co, output bit z, output bit e);
      int full;
      res = 0; co = 0; e = 0;
      case (rm)
         0: begin full = ra + rb + rc; res = full & MASK; co = (full > MASK); end
         1: begin res = (ra - rb) & MASK; co = (ra >= rb); end
         2: res = ra ^ rb;
         3: res = ra & rb;
         4: res = ra | rb;
         5: begin full = ra * rb; res = full & MASK; co = (full > MASK); end
         default: e = 1;
      endcase
      z = (res == 0);
   endfunction

   // Present one op from IDLE; returns edges from accept to out_valid, -1 on timeout.
   task automatic run_op(input int ta, input int tbv, input int tm, input int tc, output int lat);
      in_valid = 1'b1;
      a = W'(ta); b = W'(tbv); mode = 3'(tm); c_in = 1'(tc);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      // Power-on reset values.
      n_cmp++;
      if ({out_valid, in_ready, result, c_out, zero, err} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
         n_bad++;
         $display("FAIL reset_init: got ov=%b ir=%b res=%h co=%b z=%b e=%b, want ov=0 ir=1 res=00 co=0 z=0 e=0",
                  out_valid, in_ready, result, c_out, zero, err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // Reset asserted mid-run, while a result is held, takes effect without an edge.
      run_op(200, 100, 0, 1, lat);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, result, c_out, zero, err} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
         n_bad++;
         $display("FAIL reset_async: got ov=%b ir=%b res=%h co=%b z=%b e=%b, want ov=0 ir=1 res=00 co=0 z=0 e=0",
                  out_valid, in_ready, result, c_out, zero, err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      // a, b, mode, c_in, result, c_out, zero, latency
      int tbl [10][8] = '{
         '{200, 100, 0, 1, 8'h2D, 1, 0, 0},
         '{5,   7,   1, 0, 8'hFE, 0, 0, 0},
         '{7,   7,   1, 0, 8'h00, 1, 1, 0},
         '{255, 1,   0, 0, 8'h00, 1, 1, 0},
         '{240, 60,  2, 0, 8'hCC, 0, 0, 0},
         '{240, 60,  3, 0, 8'h30, 0, 0, 0},
         '{240, 60,  4, 0, 8'hFC, 0, 0, 0},
         '{15,  17,  5, 0, 8'hFF, 0, 0, 8},
         '{16,  16,  5, 0, 8'h00, 1, 1, 8},
         '{255, 255, 5, 0, 8'h01, 1, 0, 8}
      };
      int lat;
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], lat);
         n_cmp++;
         if ({result, c_out, zero, err} !== {8'(tbl[i][4]), 1'(tbl[i][5]), 1'(tbl[i][6]), 1'b0}) begin
            n_bad++;
            $display("FAIL directed[%0d]: got res=%h co=%b z=%b e=%b, want res=%h co=%0d z=%0d e=0",
                     i, result, c_out, zero, err, tbl[i][4], tbl[i][5], tbl[i][6]);
         end
         n_cmp++;
         if (lat != tbl[i][7]) begin
            n_bad++;
            $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, tbl[i][7]);
         end
         release_result();
      end
   endtask

   task automatic test_illegal();
      int lat;
      for (int m = 6; m <= 7; m++) begin
         run_op(8'hAA, 8'h55, m, 1, lat);
         n_cmp++;
         if ({out_valid, result, c_out, zero, err} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL illegal_mode%0d: got ov=%b res=%h co=%b z=%b e=%b, want ov=1 res=00 co=0 z=1 e=1",
                     m, out_valid, result, c_out, zero, err);
         end
         release_result();
      end
      run_op(1, 2, 0, 0, lat);
      n_cmp++;
      if ({result, c_out, zero, err} !== {8'h03, 3'b000}) begin
         n_bad++;
         $display("FAIL illegal_clear: got res=%h co=%b z=%b e=%b, want res=03 co=0 z=0 e=0",
                  result, c_out, zero, err);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [W+2:0] held;
      run_op(8'h12, 8'h34, 0, 0, lat);
      held = {result, c_out, zero, err};
      // New request while DONE must be ignored.
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF; mode = 3'd5;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({out_valid, in_ready, result, c_out, zero, err} !== {1'b1, 1'b0, held}) begin
            n_bad++;
            $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b outs=%h, want ov=1 ir=0 outs=%h",
                     i, out_valid, in_ready, {result, c_out, zero, err}, held);
         end
      end
      in_valid = 1'b0;
      release_result();
      n_cmp++;
      if ({out_valid, in_ready, result, c_out, zero, err} !== {1'b0, 1'b1, held}) begin
         n_bad++;
         $display("FAIL backpressure_release: got ov=%b ir=%b outs=%h, want ov=0 ir=1 outs=%h",
                  out_valid, in_ready, {result, c_out, zero, err}, held);
      end
      run_op(8'h0F, 8'hA0, 4, 0, lat);
      n_cmp++;
      if ({result, c_out, err} !== {8'hAF, 2'b00} || lat != 0) begin
         n_bad++;
         $display("FAIL backpressure_next: got res=%h co=%b e=%b lat=%0d, want res=AF co=0 e=0 lat=0",
                  result, c_out, err, lat);
      end
      release_result();
   endtask

   task automatic test_mul_toggle();
      int  lat;
      int  er;
      bit  eco, ez, ee;
      ref_op(8'hB7, 8'h5D, 5, 0, er, eco, ez, ee);
      in_valid = 1'b1; a = 8'hB7; b = 8'h5D; mode = 3'd5; c_in = 1'b0;
      @(posedge clk); #1;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 64) begin
         // Keep offering junk operations; they must not disturb the multiply.
         a = W'($urandom); b = W'($urandom); mode = 3'($urandom_range(0, 7));
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, result, c_out, zero, err} !== {1'b1, 8'(er), eco, ez, 1'b0} || lat != W) begin
         n_bad++;
         $display("FAIL mul_toggle: got ov=%b res=%h co=%b z=%b e=%b lat=%0d, want ov=1 res=%h co=%b z=%b e=0 lat=%0d",
                  out_valid, result, c_out, zero, err, lat, er, eco, ez, W);
      end
      release_result();
   endtask

   task automatic test_mul_abort();
      int lat;
      bit seen;
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF; mode = 3'd5; c_in = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, result, c_out, err} !== {1'b0, 1'b1, 8'h00, 2'b00}) begin
         n_bad++;
         $display("FAIL mul_abort_reset: got ov=%b ir=%b res=%h co=%b e=%b, want ov=0 ir=1 res=00 co=0 e=0",
                  out_valid, in_ready, result, c_out, err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mul_abort_quiet: got out_valid_seen=%b ir=%b, want out_valid_seen=0 ir=1", seen, in_ready);
      end
      run_op(3, 4, 5, 0, lat);
      n_cmp++;
      if ({result, c_out} !== {8'd12, 1'b0} || lat != W) begin
         n_bad++;
         $display("FAIL mul_abort_next: got res=%h co=%b lat=%0d, want res=0c co=0 lat=%0d", result, c_out, lat, W);
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      int ones;
      int wrong;
      ones = 0; wrong = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      a = 8'h21; b = 8'h43; mode = 3'd0; c_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            ones++;
            if (result !== 8'h64) wrong++;
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (ones != 5 || wrong != 0) begin
         n_bad++;
         $display("FAIL back_to_back: got %0d results (%0d wrong) in 10 edges, want 5 results (0 wrong)", ones, wrong);
      end
   endtask

   task automatic test_random();
      int ra, rb, rm, rc, er, lat, hold;
      bit eco, ez, ee;
      for (int i = 0; i < 150; i++) begin
         ra = int'($urandom_range(0, MASK));
         rb = int'($urandom_range(0, MASK));
         rm = int'($urandom_range(0, 7));
         rc = int'($urandom_range(0, 1));
         ref_op(ra, rb, rm, rc, er, eco, ez, ee);
         run_op(ra, rb, rm, rc, lat);
         n_cmp++;
         if ({result, c_out, zero, err} !== {8'(er), eco, ez, ee} || lat != ((rm == 5) ? W : 0)) begin
            n_bad++;
            $display("FAIL random[%0d] a=%0d b=%0d m=%0d ci=%0d: got res=%h co=%b z=%b e=%b lat=%0d, want res=%h co=%b z=%b e=%b lat=%0d",
                     i, ra, rb, rm, rc, result, c_out, zero, err, lat, er, eco, ez, ee, (rm == 5) ? W : 0);
         end
         hold = int'($urandom_range(0, 3));
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
         end
         release_result();
         n_cmp++;
         if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 8'(er)}) begin
            n_bad++;
            $display("FAIL random_release[%0d]: got ir=%b ov=%b res=%h, want ir=1 ov=0 res=%h",
                     i, in_ready, out_valid, result, er);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; mode = '0; c_in = 1'b0;
      #1;
      test_reset();
      test_directed();
      test_illegal();
      test_backpressure();
      test_mul_toggle();
      test_mul_abort();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the lab's 3-bit combinational ALU. It accepts one operation per valid/ready handshake and computes add, subtract, XOR, AND and OR in one cycle. Unsigned multiply is computed iteratively by shift-add over WIDTH cycles. The result is held in an output register until the consumer takes it, so the block can sit between a switch/register front end and a display or accumulator stage.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- mode  input  3  operation select; see Operation.
- c_in  input  1  carry-in, used by ADD only.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- c_out  output  1  registered carry / no-borrow / multiply-overflow.
- zero  output  1  registered; 1 when result == 0.
- err  output  1  registered; 1 when mode was illegal.

## Operation
- **Clock and reset.** One clock. Reset is asynchronous and active-low.
- **Operand capture.** An operation is accepted on a rising edge where in_valid && in_ready. At that edge a, b, mode and c_in are captured.
- **Mode 000, ADD.** {c_out, result} = a + b + c_in, computed at WIDTH+1 bits.
- **Mode 001, SUB.** {c_out, result} = a + ~b + 1. c_in is ignored. c_out = 1 means no borrow (a >= b).
- **Mode 010, XOR.** result = a ^ b; c_out = 0.
- **Mode 011, AND.** result = a & b; c_out = 0.
- **Mode 100, OR.** result = a | b; c_out = 0.
- **Mode 101, MUL.** The full product is 2·WIDTH bits, unsigned. result = low WIDTH bits. c_out = 1 if the high WIDTH bits are nonzero.
- **Modes 110/111, illegal.** result = 0, c_out = 0, zero = 1, err = 1.
- **err.** err = 0 for every legal mode.
- **State machine states:**
  - IDLE: in_ready = 1, out_valid = 0.
  - MUL: iterating; in_ready = 0, out_valid = 0.
  - DONE: out_valid = 1, in_ready = 0.
- **State transitions:**
  - IDLE → DONE on accept of any non-MUL mode, including illegal modes. Output registers are loaded at the same edge.
  - IDLE → MUL on accept of MUL. Captured A, B are loaded, the product accumulator is cleared, and the iteration counter is set to 0.
  - MUL: one iteration per cycle. If B[0] is set, add A shifted by the iteration index into the 2·WIDTH accumulator; shift B right; increment the counter. After exactly WIDTH iterations, load the outputs and go to DONE.
  - DONE → IDLE on out_ready = 1.
- **Output stability.** result, c_out, zero and err hold their values while in DONE and until the next load. They are not cleared on return to IDLE.
- **Ignored inputs.** in_valid is ignored outside IDLE, and input changes while in MUL do not affect the running operation. out_ready is ignored outside DONE.
- **Counter width.** The counter is wide enough to hold WIDTH (clog2(WIDTH+1) bits).

## Timing
- **Reset values.** While rst_n = 0: state = IDLE, in_ready = 1, out_valid = 0, result = 0, c_out = 0, zero = 0, err = 0. The multiply accumulator and counter are also cleared.
- **Reset mid-operation.** Reset asserted during MUL or DONE aborts the operation immediately. The partial result is never presented.
- **Single-cycle ops.** Accept at edge k; out_valid = 1 and result valid after edge k+1... more precisely, the outputs are loaded at edge k itself, so out_valid and result are visible in the cycle following edge k.
- **MUL latency.** Accept at edge k; the WIDTH iterations occur at edges k+1..k+WIDTH; out_valid rises after edge k+WIDTH.
- **Throughput.**
  - Best case, single-cycle ops with out_ready held 1: one operation per 2 cycles, since DONE → IDLE takes one edge.
  - Best case, MUL: one operation per WIDTH+2 cycles.
- **Backpressure.** With out_ready = 0, DONE is held indefinitely. Outputs stay bit-stable and in_ready stays 0.
- **Port timing.** in_ready and out_valid are decoded from the state register only; there is no combinational path from inputs to outputs.

## Test plan
- **Reset.** Assert rst_n = 0 mid-run → out_valid = 0, in_ready = 1, result = 0x00, err = 0 with no clock edge required.
- **ADD with carry.** WIDTH = 8, ADD a = 200, b = 100, c_in = 1 → result = 0x2D, c_out = 1, zero = 0, out_valid the cycle after accept.
- **SUB, ADD wrap, logic ops.**
  - SUB a = 5, b = 7 → result = 0xFE, c_out = 0.
  - SUB a = 7, b = 7 → result = 0x00, c_out = 1, zero = 1.
  - ADD a = 0xFF, b = 0x01, c_in = 0 → result = 0x00, c_out = 1, zero = 1.
  - XOR / AND / OR of 0xF0 and 0x3C → 0xCC / 0x30 / 0xFC, c_out = 0 each.
- **MUL.**
  - a = 15, b = 17 → result = 0xFF, c_out = 0, out_valid exactly 8 edges after the accept edge.
  - a = 16, b = 16 → result = 0x00, c_out = 1, zero = 1.
  - a = 255, b = 255 → result = 0x01, c_out = 1.
- **Backpressure and mid-operation abort.**
  - Hold out_ready = 0 for 10 cycles after a result → outputs constant and in_ready = 0 throughout. Then pulse out_ready for 1 cycle → IDLE, and the next op is accepted.
  - Toggle a/b during MUL → result unaffected.
  - Assert reset at iteration 4 of MUL → IDLE, and no out_valid pulse.
- **Illegal modes.** mode = 110 and mode = 111 → result = 0, zero = 1, err = 1, c_out = 0. A following ADD clears err to 0.
